ngp_alu_ctrl: RTL and testbench

//   Shares the single combinational core ALU between NREQ requesters (fetch-side address calc,

---
 rtl/ngp_alu_pkg.sv | 35 +++
 rtl/ngp_rr_arb.sv | 33 +++
 rtl/ngp_alu_ctrl.sv | 102 ++++++++++
 tb/tb_ngp_alu_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ngp_alu_pkg.sv
// Shared types for the ALU request controller: opcode encoding, legality check, FSM states.
package ngp_alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_OR   = 4'h1,
    OP_XOR  = 4'h2,
    OP_NOT  = 4'h3,
    OP_SHR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SRA  = 4'h6,
    OP_ADD  = 4'h8,
    OP_SUB  = 4'h9,
    OP_ADDC = 4'hA,
    OP_SUBB = 4'hB
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;

  // 0x7 and 0xC-0xF have no ALU meaning; those requests get an error response.
  function automatic logic is_legal_op(alu_op_e op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHR, OP_SHL, OP_SRA,
      OP_ADD, OP_SUB, OP_ADDC, OP_SUBB: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ngp_rr_arb.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping.
// Purely combinational; grant is one-hot, grant_idx its binary index, any = some request set.
module ngp_rr_arb #(
  parameter int NREQ = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    // Walk from farthest to nearest so the candidate closest to ptr wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ngp_alu_ctrl.sv
// Shares one combinational ALU among NREQ requesters, one op in flight (IDLE->EXEC->RESP).
// Optional NGP_ALU_CTRL_FLAGS_EN adds resp_flags = {neg, zero} captured with the result.
module ngp_alu_ctrl
  import ngp_alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = ALU_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*4-1:0] req_op,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [3:0]        alu_op,
  output logic [W-1:0]      alu_x,
  output logic [W-1:0]      alu_y,
  input  logic [W-1:0]      alu_result,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W-1:0]      resp_data,
  output logic              resp_err,
  output logic [1:0]        dbg_state
`ifdef NGP_ALU_CTRL_FLAGS_EN
  ,
  output logic [1:0]        resp_flags
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshakes: a request transfers when req_valid[i] && req_ready[i] at a rising edge;
  // a response transfers when resp_valid[g] && resp_ready[g]. Valid never drops without ready.
  ctrl_state_e       state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     grant_q;
  logic [NREQ-1:0]   arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic              op_legal;

  ngp_rr_arb #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Reset gates req_ready so nothing is offered while the FSM is held.
  assign req_ready = (state == IDLE && !rst) ? arb_grant : '0;
  assign dbg_state = state;
  assign op_legal  = is_legal_op(alu_op_e'(alu_op));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_q    <= '0;
      alu_op     <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
`ifdef NGP_ALU_CTRL_FLAGS_EN
      resp_flags <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            alu_op  <= req_op[arb_idx*4 +: 4];
            alu_x   <= req_x[arb_idx*W +: W];
            alu_y   <= req_y[arb_idx*W +: W];
            grant_q <= arb_idx;
            rr_ptr  <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          resp_data  <= op_legal ? alu_result : '0;
          resp_err   <= !op_legal;
`ifdef NGP_ALU_CTRL_FLAGS_EN
          resp_flags <= {op_legal & alu_result[W-1], op_legal & (alu_result == '0)};
`endif
          resp_valid <= NREQ'(1) << grant_q;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready[grant_q]) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ngp_alu_ctrl.sv
// Directed bench for ngp_alu_ctrl; the bench also plays the combinational ALU.
// Build with NGP_ALU_CTRL_FLAGS_EN defined to exercise resp_flags.
module tb_ngp_alu_ctrl;
  import ngp_alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*4-1:0] req_op = '0;
  logic [NREQ*W-1:0] req_x = '0;
  logic [NREQ*W-1:0] req_y = '0;
  logic [3:0]        alu_op;
  logic [W-1:0]      alu_x;
  logic [W-1:0]      alu_y;
  logic [W-1:0]      alu_result;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready = '0;
  logic [W-1:0]      resp_data;
  logic              resp_err;
  logic [1:0]        dbg_state;
`ifdef NGP_ALU_CTRL_FLAGS_EN
  logic [1:0]        resp_flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  ngp_alu_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .alu_op     (alu_op),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .dbg_state  (dbg_state)
`ifdef NGP_ALU_CTRL_FLAGS_EN
    ,
    .resp_flags (resp_flags)
`endif
  );

  // ---- clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---- ALU stand-in
  function automatic logic [W-1:0] alu_model(input logic [3:0] op, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    case (op)
      4'h0: return x & y;
      4'h1: return x | y;
      4'h2: return x ^ y;
      4'h3: return ~x;
      4'h4: return x >> y[3:0];
      4'h5: return x << y[3:0];
      4'h6: return W'($signed(x) >>> y[3:0]);
      4'h8: return x + y;
      4'h9: return x - y;
      4'hA: return x + y + 1'b1;
      4'hB: return x - y - 1'b1;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_x, alu_y);

  // ---- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y);
    req_valid[i]       = 1'b1;
    req_op[i*4 +: 4]   = op;
    req_x[i*W +: W]    = x;
    req_y[i*W +: W]    = y;
  endtask

  task automatic do_reset();
    req_valid  = '0;
    resp_ready = '0;
    rst        = 1'b1;
    tick();
    rst        = 1'b0;
    tick();
  endtask

  // ---- scenarios
  task automatic test_reset();
    tick();
    n_checks++;
    if ({req_ready, resp_valid, resp_data, resp_err, alu_op, alu_x, alu_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h err=%b op=%h x=%h y=%h expected all 0",
               req_ready, resp_valid, resp_data, resp_err, alu_op, alu_x, alu_y);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_no_ready: got %b expected 00", req_ready);
    end
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_op();
    resp_ready = 2'b01;
    set_req(0, 4'h8, 16'h0003, 16'h0004);
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    tick();
    req_valid = '0;
    n_checks++;
    if (dbg_state !== EXEC || alu_op !== 4'h8 || alu_x !== 16'h0003 || alu_y !== 16'h0004
        || req_ready !== 2'b00 || resp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL single_exec: got st=%0d op=%h x=%h y=%h rdy=%b vld=%b expected 1 8 0003 0004 00 00",
               dbg_state, alu_op, alu_x, alu_y, req_ready, resp_valid);
    end
    tick();
    n_checks++;
    if (resp_valid !== 2'b01 || resp_data !== 16'h0007 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp: got vld=%b data=%h err=%b expected 01 0007 0",
               resp_valid, resp_data, resp_err);
    end
    tick();
    n_checks++;
    if (resp_valid !== 2'b00 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL single_done: got vld=%b st=%0d expected 00 0", resp_valid, dbg_state);
    end
  endtask

  task automatic test_ops();
    logic [3:0]   ops [8] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    logic [W-1:0] xs  [8] = '{16'hF0F0, 16'h1200, 16'h00FF, 16'h8000, 16'h0001, 16'h8000,
                              16'h0001, 16'h0005};
    logic [W-1:0] ys  [8] = '{16'h0FF0, 16'h0034, 16'h0000, 16'h0004, 16'h0004, 16'h0004,
                              16'h0002, 16'h0002};
    logic [W-1:0] exp [8] = '{16'h00F0, 16'h1234, 16'hFF00, 16'h0800, 16'h0010, 16'hF800,
                              16'h0004, 16'h0002};
    do_reset();
    resp_ready = 2'b01;
    for (int i = 0; i < 8; i++) begin
      set_req(0, ops[i], xs[i], ys[i]);
      tick();
      req_valid = '0;
      tick();
      n_checks++;
      if (resp_valid !== 2'b01 || resp_data !== exp[i] || resp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL op_%h: got vld=%b data=%h err=%b expected 01 %h 0",
                 ops[i], resp_valid, resp_data, resp_err, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int gcount;
    int exp_g;
    logic [W-1:0] exp_v;
    do_reset();
    resp_ready = 2'b11;
    set_req(0, 4'h8, 16'h0010, 16'h0001);
    set_req(1, 4'h9, 16'h0020, 16'h0001);
    gcount = 0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (req_ready !== 2'b00) begin
        exp_g = gcount % 2;
        n_checks++;
        if (req_ready !== (2'b01 << exp_g) || c != 3 * gcount) begin
          n_fail++;
          $display("FAIL rr_grant%0d: got rdy=%b cycle=%0d expected rdy=%b cycle=%0d",
                   gcount, req_ready, c, 2'b01 << exp_g, 3 * gcount);
        end
        exp_q.push_back(exp_g == 0 ? 16'h0011 : 16'h001F);
        gcount++;
      end
      if (resp_valid !== 2'b00) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rr_resp: got unexpected data=%h expected no response", resp_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (resp_data !== exp_v) begin
            n_fail++;
            $display("FAIL rr_resp: got %h expected %h", resp_data, exp_v);
          end
        end
      end
      tick();
      if (gcount == 4) req_valid = '0;
    end
    n_checks++;
    if (gcount != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_count: got grants=%0d pending=%0d expected 4 0", gcount, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 4'h9, 16'h0005, 16'h0007);
    set_req(1, 4'h8, 16'h0001, 16'h0001);
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_ready: got %b expected 01", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    resp_ready   = 2'b10;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (resp_valid !== 2'b01 || resp_data !== 16'hFFFE || resp_err !== 1'b0
          || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got vld=%b data=%h err=%b rdy=%b expected 01 fffe 0 00",
                 k, resp_valid, resp_data, resp_err, req_ready);
      end
      if (k == 3) resp_ready = 2'b01;
      tick();
    end
    n_checks++;
    if (resp_valid !== 2'b00 || req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b rdy=%b expected 00 10", resp_valid, req_ready);
    end
    tick();
    req_valid  = '0;
    resp_ready = 2'b11;
    tick();
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    resp_ready = 2'b10;
    set_req(1, 4'hC, 16'h1234, 16'h0000);
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL illegal_ready: got %b expected 10", req_ready);
    end
    tick();
    req_valid = '0;
    n_checks++;
    if (alu_op !== 4'hC) begin
      n_fail++;
      $display("FAIL illegal_aluop: got %h expected c", alu_op);
    end
    tick();
    n_checks++;
    if (resp_valid !== 2'b10 || resp_err !== 1'b1 || resp_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL illegal_c: got vld=%b err=%b data=%h expected 10 1 0000",
               resp_valid, resp_err, resp_data);
    end
`ifdef NGP_ALU_CTRL_FLAGS_EN
    n_checks++;
    if (resp_flags !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_flags: got %b expected 00", resp_flags);
    end
`endif
    tick();
    resp_ready = 2'b01;
    set_req(0, 4'h7, 16'hFFFF, 16'h0001);
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if (resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL illegal_7: got vld=%b err=%b data=%h expected 01 1 0000",
               resp_valid, resp_err, resp_data);
    end
    tick();
  endtask

  task automatic test_reset_exec();
    do_reset();
    resp_ready = 2'b11;
    set_req(0, 4'h8, 16'h0002, 16'h0002);
    tick();
    req_valid = '0;
    n_checks++;
    if (dbg_state !== EXEC) begin
      n_fail++;
      $display("FAIL rstx_exec: got %0d expected %0d", dbg_state, EXEC);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== IDLE || {resp_valid, resp_data, resp_err, alu_op, alu_x, alu_y} !== '0) begin
      n_fail++;
      $display("FAIL rstx_clear: got st=%0d vld=%b data=%h err=%b op=%h x=%h y=%h expected all 0",
               dbg_state, resp_valid, resp_data, resp_err, alu_op, alu_x, alu_y);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (resp_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL rstx_noresp%0d: got %b expected 00", k, resp_valid);
      end
    end
    set_req(0, 4'h0, 16'h0001, 16'h0001);
    set_req(1, 4'h0, 16'h0001, 16'h0001);
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rstx_ptr: got %b expected 01", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

`ifdef NGP_ALU_CTRL_FLAGS_EN
  task automatic test_flags();
    do_reset();
    resp_ready = 2'b11;
    set_req(0, 4'h1, 16'h8000, 16'h0000);
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if (resp_flags !== 2'b10 || resp_data !== 16'h8000) begin
      n_fail++;
      $display("FAIL flags_neg: got flags=%b data=%h expected 10 8000", resp_flags, resp_data);
    end
    tick();
    set_req(1, 4'h2, 16'h00FF, 16'h00FF);
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if (resp_flags !== 2'b01 || resp_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL flags_zero: got flags=%b data=%h expected 01 0000", resp_flags, resp_data);
    end
    tick();
  endtask
`endif

  // ---- sequence and report
  initial begin
    test_reset();
    test_single_op();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_exec();
`ifdef NGP_ALU_CTRL_FLAGS_EN
    test_flags();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
